// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, inverse-cipher FSM states and the
// GF(2^8) helpers used by the iterative inverse round datapath.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_inv_fsm_t;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // InvMixColumns on one 32-bit column; row0 is the MSB byte.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // InvShiftRows: row r rotates right by r; byte k sits at [127-8k -: 8],
  // column c holds bytes 4c..4c+3.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 is the leftmost byte of the table.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one InvCipher round per clock over a
// single shared round datapath, using the encrypt-side round-key bus.
//
// Handshake: a block moves on any rising edge where its valid and ready are
// both high. aes_c_rdy is high only in IDLE (and low while rst is high);
// aes_p_vld is high only in DONE, and aes_p_out holds until aes_p_rdy takes
// it. Valid outside its accepting state is ignored, never queued.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aes_c_vld,
  output logic                aes_c_rdy,
  input  logic [127:0]        aes_c_in,
  input  logic [10:0][127:0]  aes_key_in,
  output logic [127:0]        aes_p_out,
  output logic                aes_p_vld,
  input  logic                aes_p_rdy,
  output aes_inv_fsm_t        o_dbg_state
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes_inv_cipher: NR must be 10 for AES-128");
  end

  aes_inv_fsm_t r_fsm;
  aes_inv_fsm_t w_fsm_nxt;
  logic [127:0] r_state;
  logic [127:0] w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;

  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_rkey;
  logic [127:0] w_ark;
  logic [127:0] w_imc;

  assign w_isr  = inv_shift_rows(r_state);
  // Keys are not latched; the counter selects the live round key.
  assign w_rkey = aes_key_in[r_cnt];
  assign w_ark  = w_isb ^ w_rkey;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .i_byte (w_isr[8*g +: 8]),
      .o_byte (w_isb[8*g +: 8])
    );
  end

  // InvMixColumns applied column by column to the key-added state.
  always_comb begin
    w_imc = '0;
    for (int c = 0; c < 4; c++) begin
      w_imc[127 - 32*c -: 32] = inv_mix_column(w_ark[127 - 32*c -: 32]);
    end
  end

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    aes_c_rdy   = 1'b0;
    aes_p_vld   = 1'b0;
    aes_p_out   = '0;
    case (r_fsm)
      IDLE: begin
        aes_c_rdy = ~rst;
        if (aes_c_vld) begin
          w_state_nxt = aes_c_in ^ aes_key_in[NR];
          w_cnt_nxt   = 4'(NR - 1);
          w_fsm_nxt   = ROUND;
        end
      end
      ROUND: begin
        if (r_cnt != 4'd0) begin
          w_state_nxt = w_imc;
          w_cnt_nxt   = r_cnt - 4'd1;
        end else begin
          // Final round skips InvMixColumns.
          w_state_nxt = w_ark;
          w_fsm_nxt   = DONE;
        end
      end
      DONE: begin
        aes_p_vld = 1'b1;
        aes_p_out = r_state;
        if (aes_p_rdy) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Block state and round counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_dbg_state = r_fsm;

endmodule
